// File: rtl/io_bus_hub_if.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_hub_if
// Description : CPU-side port bus of the I/O hub. This covers the access strobe,
//               the address and write data, and the read data, ack and irq.
// Revision    : 1.0 - initial release
// ============================================================================
interface io_bus_hub_if #(
  parameter int DATA_W = 16,
  parameter int DEV_W  = 3,
  parameter int REG_W  = 2
);
  logic                     req;
  logic                     we;
  logic [DEV_W+REG_W-1:0]   dirport;
  logic [DATA_W-1:0]        outport;
  logic [DATA_W-1:0]        inport;
  logic                     ack;
  logic                     irq;

  modport master (
    output req, we, dirport, outport,
    input  inport, ack, irq
  );

  modport slave (
    input  req, we, dirport, outport,
    output inport, ack, irq
  );
endinterface
`default_nettype wire

// File: rtl/io_bus_hub.sv
`default_nettype none
// ============================================================================
// Module      : io_bus_hub
// Description : Registers each CPU port access and drives a one-hot chip select
//               to N_DEV peripherals. It waits for the selected device's ready,
//               with a timeout. It also hosts PENDING/MASK/STATUS/ID registers
//               and an edge-triggered, maskable interrupt aggregator in the top
//               device slot.
// Revision    : 1.0 - initial release
// ============================================================================
module io_bus_hub #(
  parameter int DATA_W = 16,
  parameter int DEV_W  = 3,
  parameter int REG_W  = 2,
  parameter int N_DEV  = 7,
  parameter int TO_CYC = 15
) (
  input  wire logic                    clk_i,
  input  wire logic                    reset_ni,
  io_bus_hub_if.slave                  bus,
  output logic [N_DEV-1:0]             dev_cs_o,
  output logic                         dev_we_o,
  output logic [REG_W-1:0]             dev_reg_sel_o,
  output logic [DATA_W-1:0]            dev_wdata_o,
  input  wire logic [N_DEV*DATA_W-1:0] dev_rdata_i,
  input  wire logic [N_DEV-1:0]        dev_ready_i,
  input  wire logic [N_DEV-1:0]        dev_irq_i
);

  localparam logic [DEV_W-1:0] NDEV_SEL = DEV_W'(N_DEV);
  localparam logic [DEV_W-1:0] HUB_SLOT = '1;
  localparam logic [N_DEV-1:0] CS_ONE   = N_DEV'(1);
  localparam logic [7:0]       TO_LAST  = 8'(TO_CYC - 1);
  localparam logic [REG_W-1:0] REG_PEND = REG_W'(0);
  localparam logic [REG_W-1:0] REG_MASK = REG_W'(1);
  localparam logic [REG_W-1:0] REG_STAT = REG_W'(2);
  localparam logic [REG_W-1:0] REG_ID   = REG_W'(3);
  localparam logic [15:0]      ID_VAL   = {8'(N_DEV), 8'(DATA_W)};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e              state_q;
  logic                ack_q;
  logic [DATA_W-1:0]   inport_q;
  logic [N_DEV-1:0]    dev_cs_q;
  logic                we_q;
  logic [DEV_W-1:0]    dev_q;
  logic [REG_W-1:0]    reg_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [7:0]          cnt_q;

  logic [N_DEV-1:0]    irq_s_q, irq_d1_q;
  logic [N_DEV-1:0]    pending_q, pending_d;
  logic [N_DEV-1:0]    mask_q, mask_d;
  logic                to_q, to_d;
  logic                unmap_q, unmap_d;
  logic [DEV_W-1:0]    sdev_q, sdev_d;
  logic                irq_q;

  logic [DEV_W-1:0]    sel_dev;
  logic [REG_W-1:0]    sel_reg;
  logic                accept, is_dev, is_hub, is_unmap, hub_wr;
  logic                dev_hit, dev_tmo;
  logic [N_DEV-1:0]    irq_rise;
  logic [DATA_W-1:0]   hub_rdata;
  logic [DATA_W-1:0]   dev_rdata_sel;

  assign sel_dev  = bus.dirport[DEV_W+REG_W-1 -: DEV_W];
  assign sel_reg  = bus.dirport[REG_W-1:0];
  assign accept   = (state_q == S_IDLE) && bus.req;
  assign is_dev   = sel_dev < NDEV_SEL;
  assign is_hub   = sel_dev == HUB_SLOT;
  assign is_unmap = !is_dev && !is_hub;
  assign hub_wr   = accept && is_hub && bus.we;

  // The chip select is one-hot and only set in ACCESS, so it doubles as the device index.
  assign dev_hit  = (state_q == S_ACCESS) && (|(dev_ready_i & dev_cs_q));
  assign dev_tmo  = (state_q == S_ACCESS) && !dev_hit && (cnt_q == TO_LAST);
  assign irq_rise = irq_s_q & ~irq_d1_q;

  // Read data of the selected device, muxed by the one-hot chip select.
  always_comb begin
    dev_rdata_sel = '0;
    for (int i = 0; i < N_DEV; i++) begin
      if (dev_cs_q[i]) begin
        dev_rdata_sel = dev_rdata_sel | dev_rdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Hub register read mux; values read are those before this cycle's update.
  always_comb begin
    hub_rdata = '0;
    case (sel_reg)
      REG_PEND: hub_rdata = DATA_W'(pending_q);
      REG_MASK: hub_rdata = DATA_W'(mask_q);
      REG_STAT: hub_rdata = DATA_W'({to_q, unmap_q, sdev_q});
      REG_ID:   hub_rdata = DATA_W'(ID_VAL);
      default:  hub_rdata = '0;
    endcase
  end

  // Next state of the hub registers; a new edge beats a same-cycle write-1-to-clear.
  always_comb begin
    pending_d = pending_q;
    mask_d    = mask_q;
    to_d      = to_q;
    unmap_d   = unmap_q;
    sdev_d    = sdev_q;
    if (hub_wr && (sel_reg == REG_PEND)) begin
      pending_d = pending_q & ~bus.outport[N_DEV-1:0];
    end
    pending_d = pending_d | irq_rise;
    if (hub_wr && (sel_reg == REG_MASK)) begin
      mask_d = bus.outport[N_DEV-1:0];
    end
    if (hub_wr && (sel_reg == REG_STAT)) begin
      to_d    = 1'b0;
      unmap_d = 1'b0;
      sdev_d  = '0;
    end
    if (accept && is_unmap) begin
      unmap_d = 1'b1;
    end
    if (dev_tmo) begin
      to_d   = 1'b1;
      sdev_d = dev_q;
    end
  end

  // Interrupt synchroniser, edge history, hub registers and the registered irq.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      irq_s_q   <= '0;
      irq_d1_q  <= '0;
      pending_q <= '0;
      mask_q    <= '0;
      to_q      <= 1'b0;
      unmap_q   <= 1'b0;
      sdev_q    <= '0;
      irq_q     <= 1'b0;
    end else begin
      irq_s_q   <= dev_irq_i;
      irq_d1_q  <= irq_s_q;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      to_q      <= to_d;
      unmap_q   <= unmap_d;
      sdev_q    <= sdev_d;
      irq_q     <= |(pending_d & mask_d);
    end
  end

  // Access FSM: IDLE accepts, ACCESS waits on ready or timeout, DONE pulses ack.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      ack_q    <= 1'b0;
      inport_q <= '0;
      dev_cs_q <= '0;
      we_q     <= 1'b0;
      dev_q    <= '0;
      reg_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ack_q    <= 1'b0;
          inport_q <= '0;
          if (bus.req) begin
            we_q    <= bus.we;
            dev_q   <= sel_dev;
            reg_q   <= sel_reg;
            wdata_q <= bus.outport;
            if (is_dev) begin
              state_q  <= S_ACCESS;
              dev_cs_q <= CS_ONE << sel_dev;
              cnt_q    <= '0;
            end else begin
              state_q  <= S_DONE;
              ack_q    <= 1'b1;
              if (bus.we) begin
                inport_q <= '0;
              end else if (is_hub) begin
                inport_q <= hub_rdata;
              end else begin
                inport_q <= '1;
              end
            end
          end
        end
        S_ACCESS: begin
          if (dev_hit) begin
            state_q  <= S_DONE;
            ack_q    <= 1'b1;
            dev_cs_q <= '0;
            inport_q <= we_q ? '0 : dev_rdata_sel;
          end else if (dev_tmo) begin
            state_q  <= S_DONE;
            ack_q    <= 1'b1;
            dev_cs_q <= '0;
            inport_q <= '1;
          end else if (cnt_q != 8'hFF) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        S_DONE: begin
          state_q  <= S_IDLE;
          ack_q    <= 1'b0;
          inport_q <= '0;
        end
        default: begin
          state_q  <= S_IDLE;
          ack_q    <= 1'b0;
          dev_cs_q <= '0;
        end
      endcase
    end
  end

  assign bus.ack       = ack_q;
  assign bus.inport    = inport_q;
  assign bus.irq       = irq_q;
  assign dev_cs_o      = dev_cs_q;
  assign dev_we_o      = we_q;
  assign dev_reg_sel_o = reg_q;
  assign dev_wdata_o   = wdata_q;

endmodule
`default_nettype wire
